// File: rtl/readout_pkg.sv
// Shared definitions for the pixel-matrix readout controller:
// FSM state encoding, default timing constants and a saturating counter helper.
package readout_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int FRAME_LEN_DEF    = 27;   // 21 data + 6 column address bits
   localparam int FREEZE_SETUP_DEF = 4;
   localparam int DRAIN_LEN_DEF    = 3;
   localparam int MAX_READS_DEF    = 1024;
   localparam int WORD_W           = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
      return (v == {WORD_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/token_sync.sv
// Two-flop synchronizer bringing the chip token into the ClkOut domain.
module token_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // Double-register the asynchronous token; both flops clear on reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/readout_ctrl.sv
// Readout controller: freezes the matrix, strobes Read once per serialized
// frame while the token is pending, then drains before releasing Freeze.
// Optional per-window read limit with sticky timeout flag is enabled by
// defining READOUT_CTRL_TIMEOUT_EN.
module readout_ctrl
   import readout_pkg::*;
#(
   parameter int FRAME_LEN    = FRAME_LEN_DEF,
   parameter int FREEZE_SETUP = FREEZE_SETUP_DEF,
   parameter int DRAIN_LEN    = DRAIN_LEN_DEF,
   parameter int MAX_READS    = MAX_READS_DEF
) (
   input  logic              ClkOut,
   input  logic              Reset,
   input  logic              TokenOut,
   input  logic              EnRead,
   output logic              Read,
   output logic              Freeze,
   output logic              Busy,
   output logic [WORD_W-1:0] WordCnt,
   output logic              TimeoutErr
);

   localparam int PH_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int TMAX = (FREEZE_SETUP > DRAIN_LEN) ? FREEZE_SETUP : DRAIN_LEN;
   localparam int TM_W = $clog2(TMAX + 1);

   // The synchronizer latency has to fit inside one frame, and the setup
   // window cannot be empty.
   generate
      if (FRAME_LEN < 4) begin : g_bad_frame_len
         $error("readout_ctrl: FRAME_LEN must be >= 4");
      end
      if (FREEZE_SETUP < 1) begin : g_bad_freeze_setup
         $error("readout_ctrl: FREEZE_SETUP must be >= 1");
      end
      if (MAX_READS < 1) begin : g_bad_max_reads
         $error("readout_ctrl: MAX_READS must be >= 1");
      end
   endgenerate

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PH_W-1:0]   r_phase;
   logic [PH_W-1:0]   w_phase_nxt;
   logic [TM_W-1:0]   r_tmr;
   logic [TM_W-1:0]   w_tmr_nxt;
   logic [WORD_W-1:0] r_word_cnt;
   logic              w_tok_s;
   logic              w_read;
   logic              w_limit;

   token_sync u_token_sync (
      .i_clk   (ClkOut),
      .i_rst   (Reset),
      .i_async (TokenOut),
      .o_sync  (w_tok_s)
   );

   assign w_read = (r_state == READ) && (r_phase == '0);

`ifdef READOUT_CTRL_TIMEOUT_EN
   localparam int RC_W = $clog2(MAX_READS + 1);

   logic [RC_W-1:0] r_rd_cnt;
   logic            r_timeout;

   // Count Reads within one freeze window; flag sticks once the limit is hit.
   always_ff @(posedge ClkOut) begin
      if (Reset) begin
         r_rd_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == IDLE) begin
            r_rd_cnt <= '0;
         end else if (w_read && (r_rd_cnt != RC_W'(MAX_READS))) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
         end
         if (w_read && (r_rd_cnt == RC_W'(MAX_READS - 1))) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign w_limit    = (r_rd_cnt >= RC_W'(MAX_READS));
   assign TimeoutErr = r_timeout;
`else
   assign w_limit    = 1'b0;
   assign TimeoutErr = 1'b0;
`endif

   // State and timing counters register.
   always_ff @(posedge ClkOut) begin
      if (Reset) begin
         r_state <= IDLE;
         r_phase <= '0;
         r_tmr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_tmr   <= w_tmr_nxt;
      end
   end

   // Next-state logic; EnRead and the token are only consulted at frame end
   // so a frame in flight always completes.
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_tmr_nxt   = r_tmr;
      case (r_state)
         IDLE: begin
            w_phase_nxt = '0;
            w_tmr_nxt   = '0;
            if (EnRead && w_tok_s) begin
               w_state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (int'(r_tmr) >= FREEZE_SETUP - 1) begin
               w_state_nxt = READ;
               w_phase_nxt = '0;
               w_tmr_nxt   = '0;
            end else begin
               w_tmr_nxt = r_tmr + 1'b1;
            end
         end
         READ: begin
            if (int'(r_phase) >= FRAME_LEN - 1) begin
               w_phase_nxt = '0;
               if (!(w_tok_s && EnRead && !w_limit)) begin
                  w_state_nxt = DRAIN;
                  w_tmr_nxt   = '0;
               end
            end else begin
               w_phase_nxt = r_phase + 1'b1;
            end
         end
         DRAIN: begin
            if (int'(r_tmr) + 1 >= DRAIN_LEN) begin
               w_state_nxt = IDLE;
               w_tmr_nxt   = '0;
            end else begin
               w_tmr_nxt = r_tmr + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Total words read since reset, saturating.
   always_ff @(posedge ClkOut) begin
      if (Reset) begin
         r_word_cnt <= '0;
      end else if (w_read) begin
         r_word_cnt <= sat_inc(r_word_cnt);
      end
   end

   assign Read    = w_read;
   assign Freeze  = (r_state != IDLE);
   assign Busy    = (r_state != IDLE);
   assign WordCnt = r_word_cnt;

endmodule

// File: tb/tb_readout_ctrl.sv
// Directed bench for readout_ctrl with a scoreboard of expected Read cycles.
// Expectations for the read-limit scenario follow READOUT_CTRL_TIMEOUT_EN.
module tb_readout_ctrl;

   logic        ClkOut;
   logic        Reset;
   logic        TokenOut;
   logic        EnRead;
   logic        Read;
   logic        Freeze;
   logic        Busy;
   logic [15:0] WordCnt;
   logic        TimeoutErr;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int rise_cyc = -1;
   int fall_cyc = -1;
   logic frz_prev = 1'b0;
   int exp_q[$];
   int exp_rd;

   readout_ctrl #(.MAX_READS(4)) dut (
      .ClkOut     (ClkOut),
      .Reset      (Reset),
      .TokenOut   (TokenOut),
      .EnRead     (EnRead),
      .Read       (Read),
      .Freeze     (Freeze),
      .Busy       (Busy),
      .WordCnt    (WordCnt),
      .TimeoutErr (TimeoutErr)
   );

   initial ClkOut = 1'b0;
   always #5 ClkOut = ~ClkOut;

   always @(posedge ClkOut) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every Read pulse must match the next scheduled Read cycle.
   always @(negedge ClkOut) begin
      frz_prev <= Freeze;
      if (Freeze && !frz_prev) rise_cyc <= cyc;
      if (!Freeze && frz_prev) fall_cyc <= cyc;
      if (Read) begin
         exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         chk("read_cycle", cyc, exp_rd);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick_to(input int t);
      while (cyc < t) begin
         @(posedge ClkOut);
         #1;
      end
   endtask

   task automatic begin_burst(output int c);
      @(posedge ClkOut);
      #1;
      c = cyc;
      TokenOut = 1'b1;
   endtask

   initial begin
      int c;
      Reset    = 1'b1;
      TokenOut = 1'b0;
      EnRead   = 1'b0;
      repeat (3) @(posedge ClkOut);
      #1;
      @(negedge ClkOut);
      chk("rst_read", Read, 1'b0);
      chk("rst_freeze", Freeze, 1'b0);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_wordcnt", WordCnt, 16'h0000);
      chk("rst_timeout", TimeoutErr, 1'b0);
      @(posedge ClkOut);
      #1;
      Reset  = 1'b0;
      EnRead = 1'b1;
      tick_to(cyc + 4);

      // Three-frame burst: Freeze at +3, Reads at +7/+34/+61, drain to +91.
      begin_burst(c);
      exp_q.push_back(c + 7);
      exp_q.push_back(c + 34);
      exp_q.push_back(c + 61);
      tick_to(c + 81);
      TokenOut = 1'b0;
      tick_to(c + 96);
      chk("t1_freeze_rise", rise_cyc, c + 3);
      chk("t1_freeze_fall", fall_cyc, c + 91);
      chk("t1_wordcnt", WordCnt, 16'd3);
      chk("t1_missing_reads", exp_q.size(), 0);
      chk("t1_busy_idle", Busy, 1'b0);

      // Reads disabled: token pending for 100 cycles must not start a window.
      EnRead   = 1'b0;
      TokenOut = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge ClkOut);
         chk("t2_quiet", {Read, Freeze, Busy}, 3'b000);
      end
      @(posedge ClkOut);
      #1;
      TokenOut = 1'b0;
      tick_to(cyc + 5);
      EnRead = 1'b1;
      tick_to(cyc + 3);

      // Reset during phase 10 of the second frame.
      begin_burst(c);
      exp_q.push_back(c + 7);
      exp_q.push_back(c + 34);
      tick_to(c + 44);
      Reset    = 1'b1;
      TokenOut = 1'b0;
      tick_to(c + 45);
      Reset = 1'b0;
      @(negedge ClkOut);
      chk("t3_read", Read, 1'b0);
      chk("t3_freeze", Freeze, 1'b0);
      chk("t3_busy", Busy, 1'b0);
      chk("t3_wordcnt", WordCnt, 16'h0000);
      chk("t3_missing_reads", exp_q.size(), 0);
      tick_to(c + 52);

      // EnRead dropped at phase 5 of the first frame: one Read, then drain.
      begin_burst(c);
      exp_q.push_back(c + 7);
      tick_to(c + 12);
      EnRead = 1'b0;
      tick_to(c + 81);
      TokenOut = 1'b0;
      tick_to(c + 86);
      chk("t4_freeze_rise", rise_cyc, c + 3);
      chk("t4_freeze_fall", fall_cyc, c + 37);
      chk("t4_wordcnt", WordCnt, 16'd1);
      chk("t4_missing_reads", exp_q.size(), 0);
      EnRead = 1'b1;
      tick_to(cyc + 3);

      // Token gone during setup still yields one (empty) word.
      begin_burst(c);
      exp_q.push_back(c + 7);
      tick_to(c + 2);
      TokenOut = 1'b0;
      tick_to(c + 42);
      chk("t5_freeze_fall", fall_cyc, c + 37);
      chk("t5_wordcnt", WordCnt, 16'd2);
      chk("t5_missing_reads", exp_q.size(), 0);

      // Token stuck high with a limit of 4 reads per window.
      begin_burst(c);
      exp_q.push_back(c + 7);
      exp_q.push_back(c + 34);
      exp_q.push_back(c + 61);
      exp_q.push_back(c + 88);
`ifdef READOUT_CTRL_TIMEOUT_EN
      tick_to(c + 115);
      TokenOut = 1'b0;
      tick_to(c + 125);
      chk("t6_freeze_fall", fall_cyc, c + 118);
      chk("t6_timeout", TimeoutErr, 1'b1);
      chk("t6_wordcnt", WordCnt, 16'd6);
      chk("t6_missing_reads", exp_q.size(), 0);
      tick_to(c + 160);
      chk("t6_timeout_sticky", TimeoutErr, 1'b1);
`else
      exp_q.push_back(c + 115);
      tick_to(c + 115);
      TokenOut = 1'b0;
      tick_to(c + 150);
      chk("t6_freeze_fall", fall_cyc, c + 145);
      chk("t6_timeout", TimeoutErr, 1'b0);
      chk("t6_wordcnt", WordCnt, 16'd7);
      chk("t6_missing_reads", exp_q.size(), 0);
`endif
      Reset = 1'b1;
      tick_to(cyc + 2);
      Reset = 1'b0;
      @(negedge ClkOut);
      chk("t6_timeout_cleared", TimeoutErr, 1'b0);
      chk("t6_wordcnt_cleared", WordCnt, 16'h0000);
      tick_to(cyc + 3);

      // Saturation: preset to FFFE, three more Reads end at FFFF.
      @(negedge ClkOut);
      force dut.r_word_cnt = 16'hFFFE;
      @(posedge ClkOut);
      #1;
      release dut.r_word_cnt;
      @(negedge ClkOut);
      chk("t7_preset", WordCnt, 16'hFFFE);
      begin_burst(c);
      exp_q.push_back(c + 7);
      exp_q.push_back(c + 34);
      exp_q.push_back(c + 61);
      tick_to(c + 8);
      @(negedge ClkOut);
      chk("t7_after_first", WordCnt, 16'hFFFF);
      tick_to(c + 81);
      TokenOut = 1'b0;
      tick_to(c + 96);
      chk("t7_saturated", WordCnt, 16'hFFFF);
      chk("t7_missing_reads", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
